// File: rtl/elastic_config_loader_pkg.sv
// Shared constants, record/config types and loader state encoding for the PE configuration loader.
package elastic_config_loader_pkg;

  localparam int CONTEXT_SIZE            = 16;
  localparam int CONTEXT_SIZE_BIT_LENGTH = 4;
  localparam int INPUT_NUM_BIT_LENGTH    = 3;
  localparam int NEIGHBOR_PE_NUM         = 4;
  localparam int OPERATION_BIT_LENGTH    = 4;
  localparam int DATA_WIDTH              = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_START = 2'd2
  } loader_state_e;

  // One context entry as presented to the PE config port.
  typedef struct packed {
    logic [INPUT_NUM_BIT_LENGTH-1:0] in_sel_1;
    logic [INPUT_NUM_BIT_LENGTH-1:0] in_sel_2;
    logic [NEIGHBOR_PE_NUM-1:0]      out_en;
    logic [OPERATION_BIT_LENGTH-1:0] op;
    logic [DATA_WIDTH-1:0]           const_dat;
  } cfg_rec_t;

endpackage

// File: rtl/elastic_config_loader.sv
// Streams config records into consecutive PE contexts, then pulses start_exec; write lands 1 cycle after a transfer.
// Backpressure: stop_input is high outside LOAD or while load_abort is asserted; never depends on valid_input.
module elastic_config_loader
  import elastic_config_loader_pkg::*;
(
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               load_start,
  input  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] load_max_id,
  input  logic                               load_abort,
  input  logic                               valid_input,
  output logic                               stop_input,
  input  logic [INPUT_NUM_BIT_LENGTH-1:0]    rec_input_PE_index_1,
  input  logic [INPUT_NUM_BIT_LENGTH-1:0]    rec_input_PE_index_2,
  input  logic [NEIGHBOR_PE_NUM-1:0]         rec_output_PE_index,
  input  logic [OPERATION_BIT_LENGTH-1:0]    rec_op,
  input  logic [DATA_WIDTH-1:0]              rec_const_data,
  output logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_1,
  output logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_2,
  output logic [NEIGHBOR_PE_NUM-1:0]         config_output_PE_index,
  output logic [OPERATION_BIT_LENGTH-1:0]    config_op,
  output logic [DATA_WIDTH-1:0]              config_const_data,
  output logic                               write_config_data,
  output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] config_index,
  output logic                               start_exec,
  output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] mapping_context_max_id,
  output logic                               busy
);

  loader_state_e                      state_q, state_d;
  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] counter_q, counter_d;
  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] max_id_q, max_id_d;
  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] cfg_index_q, cfg_index_d;
  cfg_rec_t                           cfg_q, cfg_d;
  logic                               write_q, write_d;
  logic                               start_q, start_d;
  logic                               xfer;
  cfg_rec_t                           rec;

  assign rec = '{in_sel_1:  rec_input_PE_index_1,
                 in_sel_2:  rec_input_PE_index_2,
                 out_en:    rec_output_PE_index,
                 op:        rec_op,
                 const_dat: rec_const_data};

  // Abort gates acceptance in the same cycle so the aborted record is never written.
  assign stop_input = !((state_q == ST_LOAD) && !load_abort);
  assign xfer       = valid_input && !stop_input;

  always_comb begin
    state_d     = state_q;
    counter_d   = counter_q;
    max_id_d    = max_id_q;
    cfg_index_d = cfg_index_q;
    cfg_d       = cfg_q;
    write_d     = 1'b0;
    start_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d   = ST_LOAD;
          counter_d = '0;
          max_id_d  = load_max_id;
        end
      end
      ST_LOAD: begin
        if (load_abort) begin
          state_d = ST_IDLE;
        end else if (xfer) begin
          write_d     = 1'b1;
          cfg_d       = rec;
          cfg_index_d = counter_q;
          if (counter_q == max_id_q) begin
            state_d = ST_START;
          end else begin
            counter_d = counter_q + 1'b1;
          end
        end
      end
      ST_START: begin
        start_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      counter_q   <= '0;
      max_id_q    <= '0;
      cfg_index_q <= '0;
      cfg_q       <= '0;
      write_q     <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      max_id_q    <= max_id_d;
      cfg_index_q <= cfg_index_d;
      cfg_q       <= cfg_d;
      write_q     <= write_d;
      start_q     <= start_d;
    end
  end

  assign config_input_PE_index_1 = cfg_q.in_sel_1;
  assign config_input_PE_index_2 = cfg_q.in_sel_2;
  assign config_output_PE_index  = cfg_q.out_en;
  assign config_op               = cfg_q.op;
  assign config_const_data       = cfg_q.const_dat;
  assign config_index            = cfg_index_q;
  assign write_config_data       = write_q;
  assign start_exec              = start_q;
  assign mapping_context_max_id  = max_id_q;
  assign busy                    = (state_q != ST_IDLE);

endmodule
